typing_game_ctrl: RTL and testbench

Parametrised game controller for the typing game: holds the target text, advances a cursor on correct keystrokes, counts mistakes, runs its own countdown and sequences IDLE/RUN/PAUSE/WIN/LOSE. It sits between the PS/2 key decoder and the VGA/seven-segment drivers and replaces the fixed 200-character, count-only controller. New behaviour:
- configurable text length and code width
- mistake limit
- internal tick-driven countdown
- restart from WIN/LOSE without a reset

---
 rtl/typing_game_pkg.sv | 20 ++
 rtl/typing_key_filter.sv | 41 ++++
 rtl/typing_game_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_typing_game_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/typing_game_pkg.sv
// Shared types and constants for the typing game controller.
// State encoding matches the state output seen by the display drivers.
package typing_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } state_e;

  localparam int KEY_RELEASE = 53;
  localparam int KEY_SHIFT   = 55;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/typing_key_filter.sv
// Keystroke filter: turns the level key code into one accept per press.
// Release/shift clear the memory so a repeated letter can register again.
module typing_key_filter
  import typing_game_pkg::*;
#(
  parameter int CHAR_W  = 6,
  parameter int KEY_MAX = 52
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [CHAR_W-1:0] key_i,
  output logic              accept_o
);

  logic [CHAR_W-1:0] last_q;
  logic              is_clr_key;

  assign is_clr_key = (key_i == CHAR_W'(KEY_RELEASE))
                   || (key_i == CHAR_W'(KEY_SHIFT));

  assign accept_o = en_i
                 && (key_i != last_q)
                 && (key_i != '0)
                 && (key_i <= CHAR_W'(KEY_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
    end else if (clr_i) begin
      last_q <= '0;
    end else if (en_i) begin
      if (is_clr_key)
        last_q <= '0;
      else if (accept_o)
        last_q <= key_i;
    end
  end

endmodule

// File: rtl/typing_game_ctrl.sv
// Typing game controller: target text, cursor, mistakes, countdown
// and the IDLE/RUN/PAUSE/WIN/LOSE sequence. All outputs registered.
module typing_game_ctrl
  import typing_game_pkg::*;
#(
  parameter int N_CHARS   = 200,
  parameter int CHAR_W    = 6,
  parameter int KEY_MAX   = 52,
  parameter int ERR_LIMIT = 0,
  parameter int TIME_W    = 27,
  parameter int TIME_INIT = 1200,
  parameter int TIME_STEP = 10,
  localparam int CUR_W    = $clog2(N_CHARS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHAR_W-1:0]         key_code,
  input  logic [N_CHARS*CHAR_W-1:0] text_in,
  input  logic                      text_load,
  input  logic                      btn_up,
  input  logic                      btn_down,
  input  logic                      btn_go,
  input  logic                      btn_pause,
  input  logic                      tick,
  output logic [2:0]                state,
  output logic [CUR_W-1:0]          cursor,
  output logic [15:0]               err_cnt,
  output logic [TIME_W-1:0]         time_set,
  output logic [TIME_W-1:0]         time_left,
  output logic                      clock_go,
  output logic                      hit,
  output logic                      miss
);

  localparam logic [TIME_W-1:0] STEP   = TIME_W'(TIME_STEP);
  localparam logic [TIME_W-1:0] UP_MAX = {TIME_W{1'b1}} - STEP;
  localparam logic [16:0]       ERR_LIM = 17'(ERR_LIMIT);

  state_e                    st_q, st_d;
  logic [CUR_W-1:0]          cur_q, cur_d;
  logic [15:0]               err_q, err_d;
  logic [TIME_W-1:0]         tset_q, tset_d;
  logic [TIME_W-1:0]         tleft_q, tleft_d;
  logic [N_CHARS*CHAR_W-1:0] text_q, text_d;
  logic                      hit_q, hit_d;
  logic                      miss_q, miss_d;
  logic                      cg_q;
  logic [1:0]                up_q, dn_q;

  logic              up_rise, dn_rise;
  logic              accept, key_ok, key_bad;
  logic              is_final, err_trip;
  logic [CHAR_W-1:0] cur_char;

  assign up_rise = up_q[0] & ~up_q[1];
  assign dn_rise = dn_q[0] & ~dn_q[1];

  typing_key_filter #(
    .CHAR_W  (CHAR_W),
    .KEY_MAX (KEY_MAX)
  ) u_filter (
    .clk      (clk),
    .rst_n    (rst),
    .en_i     (st_q == ST_RUN),
    .clr_i    ((st_q == ST_PAUSE) && btn_go),
    .key_i    (key_code),
    .accept_o (accept)
  );

  always_comb begin
    cur_char = '0;
    for (int i = 0; i < N_CHARS; i++)
      if (cur_q == CUR_W'(i))
        cur_char = text_q[i*CHAR_W +: CHAR_W];
  end

  assign key_ok   = accept && (key_code == cur_char);
  assign key_bad  = accept && (key_code != cur_char);
  assign is_final = (cur_q == CUR_W'(N_CHARS - 1));
  assign err_trip = key_bad && (ERR_LIMIT != 0)
                 && (({1'b0, err_q} + 17'd1) == ERR_LIM);

  always_comb begin
    st_d    = st_q;
    cur_d   = cur_q;
    err_d   = err_q;
    tset_d  = tset_q;
    tleft_d = tleft_q;
    text_d  = text_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (text_load)
          text_d = text_in;
        if (up_rise) begin
          if (tset_q <= UP_MAX)
            tset_d = tset_q + STEP;
        end else if (dn_rise) begin
          if (tset_q >= STEP)
            tset_d = tset_q - STEP;
        end else if (btn_go) begin
          st_d = ST_RUN;
        end
        tleft_d = tset_d;
      end
      ST_RUN: begin
        if (key_ok) begin
          hit_d = 1'b1;
          cur_d = cur_q + CUR_W'(1);
        end
        if (key_bad) begin
          miss_d = 1'b1;
          err_d  = sat_inc16(err_q);
        end
        if (tick && (tleft_q != '0))
          tleft_d = tleft_q - TIME_W'(1);
        // Scoring happens regardless of which transition wins.
        if (key_ok && is_final)
          st_d = ST_WIN;
        else if (err_trip)
          st_d = ST_LOSE;
        else if (tleft_q == '0)
          st_d = ST_LOSE;
        else if (btn_pause)
          st_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (btn_go)
          st_d = ST_RUN;
      end
      ST_WIN, ST_LOSE: begin
        if (btn_go) begin
          st_d    = ST_IDLE;
          cur_d   = '0;
          err_d   = '0;
          tleft_d = tset_q;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= ST_IDLE;
      cur_q   <= '0;
      err_q   <= '0;
      tset_q  <= TIME_W'(TIME_INIT);
      tleft_q <= TIME_W'(TIME_INIT);
      text_q  <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      cg_q    <= 1'b0;
      up_q    <= 2'b00;
      dn_q    <= 2'b00;
    end else begin
      st_q    <= st_d;
      cur_q   <= cur_d;
      err_q   <= err_d;
      tset_q  <= tset_d;
      tleft_q <= tleft_d;
      text_q  <= text_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      cg_q    <= (st_d == ST_RUN);
      up_q    <= {up_q[0], btn_up};
      dn_q    <= {dn_q[0], btn_down};
    end
  end

  assign state     = st_q;
  assign cursor    = cur_q;
  assign err_cnt   = err_q;
  assign time_set  = tset_q;
  assign time_left = tleft_q;
  assign clock_go  = cg_q;
  assign hit       = hit_q;
  assign miss      = miss_q;

endmodule

// File: tb/tb_typing_game_ctrl.sv
// Bench for typing_game_ctrl: two instances (error limit 2 and 0)
// against a behavioural game model, plus directed literal checks.
module tb_typing_game_ctrl;

  localparam int NC   = 4;
  localparam int CW   = 6;
  localparam int TW   = 12;
  localparam int TI   = 1200;
  localparam int TS   = 10;
  localparam int TMAX = (1 << TW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [CW-1:0]  key = '0;
  logic [NC*CW-1:0] text = '0;
  logic tload = 0, up = 0, dn = 0, go = 0, pause = 0, tick = 0;

  logic [2:0]  st0, st1;
  logic [2:0]  cur0, cur1;
  logic [15:0] err0, err1;
  logic [TW-1:0] ts0, ts1, tl0, tl1;
  logic cg0, cg1, hit0, hit1, miss0, miss1;

  int n_tests = 0;
  int n_fail  = 0;
  int hits0   = 0;
  int misses0 = 0;
  bit chk_on  = 0;

  always #5 clk = ~clk;

  typing_game_ctrl #(
    .N_CHARS(NC), .CHAR_W(CW), .KEY_MAX(52), .ERR_LIMIT(2),
    .TIME_W(TW), .TIME_INIT(TI), .TIME_STEP(TS)
  ) u0 (
    .clk(clk), .rst(rst), .key_code(key), .text_in(text),
    .text_load(tload), .btn_up(up), .btn_down(dn), .btn_go(go),
    .btn_pause(pause), .tick(tick), .state(st0), .cursor(cur0),
    .err_cnt(err0), .time_set(ts0), .time_left(tl0),
    .clock_go(cg0), .hit(hit0), .miss(miss0)
  );

  typing_game_ctrl #(
    .N_CHARS(NC), .CHAR_W(CW), .KEY_MAX(52), .ERR_LIMIT(0),
    .TIME_W(TW), .TIME_INIT(TI), .TIME_STEP(TS)
  ) u1 (
    .clk(clk), .rst(rst), .key_code(key), .text_in(text),
    .text_load(tload), .btn_up(up), .btn_down(dn), .btn_go(go),
    .btn_pause(pause), .tick(tick), .state(st1), .cursor(cur1),
    .err_cnt(err1), .time_set(ts1), .time_left(tl1),
    .clock_go(cg1), .hit(hit1), .miss(miss1)
  );

  typedef struct packed {
    int st;
    int cur;
    int err;
    int tset;
    int tleft;
    int last;
    logic [NC*CW-1:0] txt;
    bit hit;
    bit miss;
    bit cg;
    bit u1, u2, d1, d2;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mreset();
    mdl_t r;
    r = '0;
    r.tset  = TI;
    r.tleft = TI;
    return r;
  endfunction

  // One clock of the game as described by its rules.
  function automatic mdl_t mstep(mdl_t m, int errlim);
    mdl_t n;
    bit ru, rd, acc, win, lose;
    int k, ch;
    n = m;
    ru = m.u1 && !m.u2;
    rd = m.d1 && !m.d2;
    n.u2 = m.u1; n.u1 = up;
    n.d2 = m.d1; n.d1 = dn;
    n.hit = 0; n.miss = 0;
    k = int'(key);
    case (m.st)
      0: begin
        if (tload) n.txt = text;
        if (ru) begin
          if (m.tset <= TMAX - TS) n.tset = m.tset + TS;
        end else if (rd) begin
          if (m.tset >= TS) n.tset = m.tset - TS;
        end else if (go) begin
          n.st = 1;
        end
        n.tleft = n.tset;
      end
      1: begin
        acc = (k != m.last) && (k >= 1) && (k <= 52);
        win = 0; lose = 0;
        if (k == 53 || k == 55) n.last = 0;
        else if (acc) n.last = k;
        ch = int'(m.txt[m.cur*CW +: CW]);
        if (acc && k == ch) begin
          n.hit = 1;
          n.cur = m.cur + 1;
          win = (n.cur == NC);
        end else if (acc) begin
          n.miss = 1;
          if (m.err < 65535) n.err = m.err + 1;
          lose = (errlim != 0) && (m.err + 1 == errlim);
        end
        if (tick && m.tleft > 0) n.tleft = m.tleft - 1;
        if (win) n.st = 3;
        else if (lose) n.st = 4;
        else if (m.tleft == 0) n.st = 4;
        else if (pause) n.st = 2;
      end
      2: begin
        if (go) begin n.st = 1; n.last = 0; end
      end
      default: begin
        if (go) begin
          n.st = 0; n.cur = 0; n.err = 0; n.tleft = m.tset;
        end
      end
    endcase
    n.cg = (n.st == 1);
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string id, input mdl_t m,
                     input logic [2:0] s, input logic [2:0] c,
                     input logic [15:0] e, input logic [TW-1:0] ts,
                     input logic [TW-1:0] tl, input logic g,
                     input logic h, input logic mi);
    chk({id, ".state"}, 32'(s), m.st);
    chk({id, ".cursor"}, 32'(c), m.cur);
    chk({id, ".err_cnt"}, 32'(e), m.err);
    chk({id, ".time_set"}, 32'(ts), m.tset);
    chk({id, ".time_left"}, 32'(tl), m.tleft);
    chk({id, ".clock_go"}, 32'(g), 32'(m.cg));
    chk({id, ".hit"}, 32'(h), 32'(m.hit));
    chk({id, ".miss"}, 32'(mi), 32'(m.miss));
  endtask

  always @(negedge clk) begin
    if (rst && chk_on) begin
      cmp("u0", m0, st0, cur0, err0, ts0, tl0, cg0, hit0, miss0);
      cmp("u1", m1, st1, cur1, err1, ts1, tl1, cg1, hit1, miss1);
      if (hit0) hits0++;
      if (miss0) misses0++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    if (!rst) begin
      m0 = mreset();
      m1 = mreset();
    end else begin
      m0 = mstep(m0, 2);
      m1 = mstep(m1, 0);
    end
    #1;
  endtask

  task automatic cycn(input int n);
    repeat (n) cyc();
  endtask

  task automatic press_up();
    up = 1; cycn(2); up = 0; cycn(2);
  endtask

  task automatic press_down();
    dn = 1; cycn(2); dn = 0; cycn(2);
  endtask

  task automatic pulse_go();
    go = 1; cyc(); go = 0; cyc();
  endtask

  task automatic load_text(input int c0, c1, c2, c3);
    text = {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
    tload = 1; cyc(); tload = 0;
  endtask

  task automatic type_seq(input int a, b, c);
    key = CW'(a); cycn(2); key = CW'(53); cycn(2);
    key = CW'(b); cycn(2); key = CW'(53); cycn(2);
    key = CW'(c); cycn(2);
  endtask

  task automatic do_reset();
    rst = 0; cycn(2); rst = 1; cyc();
  endtask

  initial begin
    m0 = mreset();
    m1 = mreset();
    cycn(3);
    chk("rst.state", 32'(st0), 0);
    chk("rst.time_set", 32'(ts0), 1200);
    chk("rst.time_left", 32'(tl0), 1200);
    chk("rst.clock_go", 32'(cg0), 0);
    rst = 1;
    chk_on = 1;
    cyc();

    repeat (3) press_up();
    chk("up3.time_set", 32'(ts0), 1230);
    chk("up3.time_left", 32'(tl0), 1230);

    load_text(1, 2, 3, 4);
    pulse_go();
    hits0 = 0;
    type_seq(1, 2, 3);
    key = CW'(53); cycn(2);
    key = CW'(4); cycn(2);
    key = '0; cyc();
    chk("win.hits", 32'(hits0), 4);
    chk("win.state", 32'(st0), 3);
    chk("win.cursor", 32'(cur0), 4);
    chk("win.clock_go", 32'(cg0), 0);

    pulse_go();
    chk("restart.state", 32'(st0), 0);
    chk("restart.cursor", 32'(cur0), 0);
    pulse_go();
    key = CW'(1); cycn(2); key = '0; cycn(2);
    key = CW'(1); cycn(2); key = '0; cyc();
    chk("dbl.cursor", 32'(cur0), 1);

    rst = 0; #1;
    chk("midrst.state", 32'(st0), 0);
    chk("midrst.cursor", 32'(cur0), 0);
    chk("midrst.time_set", 32'(ts0), 1200);
    chk("midrst.time_left", 32'(tl0), 1200);
    chk("midrst.clock_go", 32'(cg0), 0);
    chk("midrst.hit", 32'(hit0), 0);
    cycn(2); rst = 1; cyc();

    load_text(5, 5, 5, 5);
    pulse_go();
    misses0 = 0;
    key = CW'(6); cycn(2); key = CW'(53); cycn(2);
    key = CW'(7); cycn(2); key = '0; cyc();
    chk("errlim.misses", 32'(misses0), 2);
    chk("errlim.err_cnt", 32'(err0), 2);
    chk("errlim.state", 32'(st0), 4);
    chk("nolim.state", 32'(st1), 1);
    chk("nolim.err_cnt", 32'(err1), 2);

    do_reset();
    repeat (119) press_down();
    chk("down.time_set", 32'(ts0), 10);
    pulse_go();
    tick = 1; cycn(5); tick = 0;
    pause = 1; cyc(); pause = 0;
    tick = 1; cycn(100); tick = 0;
    chk("pause.state", 32'(st0), 2);
    chk("pause.time_left", 32'(tl0), 5);
    go = 1; cyc(); go = 0;
    tick = 1; cycn(4);
    cyc(); tick = 0;
    chk("tmo.time_left", 32'(tl0), 0);
    chk("tmo.state_t1", 32'(st0), 1);
    cyc();
    chk("tmo.state_t2", 32'(st0), 4);

    pulse_go();
    chk("lose_idle.time_left", 32'(tl0), 10);
    load_text(1, 2, 3, 4);
    pulse_go();
    tick = 1; cycn(9); tick = 0;
    type_seq(1, 2, 3);
    key = CW'(53); cycn(2);
    key = CW'(4); tick = 1; cyc(); tick = 0;
    chk("race.state", 32'(st0), 3);
    chk("race.time_left", 32'(tl0), 0);
    cyc(); key = '0;
    pulse_go();
    chk("race_idle.cursor", 32'(cur0), 0);
    chk("race_idle.state", 32'(st0), 0);

    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom % 8;
      if (r < 3)
        key = (m0.cur < NC) ? m0.txt[m0.cur*CW +: CW] : CW'(1);
      else if (r < 5) key = CW'(53);
      else if (r == 5) key = CW'(55);
      else if (r == 6) key = '0;
      else key = CW'($urandom % 64);
      tick  = ($urandom % 3) == 0;
      pause = ($urandom % 40) == 0;
      go    = ($urandom % 25) == 0;
      up    = ($urandom % 12) == 0;
      dn    = ($urandom % 12) == 0;
      tload = ($urandom % 10) == 0;
      for (int j = 0; j < NC; j++)
        text[j*CW +: CW] = CW'($urandom_range(1, 6));
      rst = ($urandom % 900) != 0;
      cyc();
    end
    key = '0; tick = 0; pause = 0; go = 0; up = 0; dn = 0; tload = 0;
    rst = 1;
    cycn(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
